// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//
// Contents:
//   arb_state_t : FSM state encoding (IDLE = 1'b0, GRANT = 1'b1)
//   STAT_W      : width of each optional per-requester write counter
//   clog2()     : ceiling log2, used to size index and counter fields
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the producers, the arbiter and the FIFO write port.
//
// Signals:
//   req          producer request bits, one per requester (level)
//   req_data     packed producer words, requester i at [i*DATA_W +: DATA_W]
//   ack          one-hot pulse when requester i's word is written
//   fifo_wr_en   FIFO write enable
//   fifo_wr_data FIFO write data
//   fifo_full    FIFO full flag
//
// Modports:
//   master : the arbiter (drives ack and the FIFO write port)
//   slave  : producers/FIFO side (drives req, req_data, fifo_full)
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic                    fifo_wr_en;
  logic [DATA_W-1:0]       fifo_wr_data;
  logic                    fifo_full;

  modport master (
    input  req, req_data, fifo_full,
    output ack, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    output req, req_data, fifo_full,
    input  ack, fifo_wr_en, fifo_wr_data
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational circular priority search.
//
// Ports:
//   req   in  N      request bits
//   ptr   in  IDX_W  last granted index; search starts at ptr+1 and wraps
//   found out 1      any request set
//   idx   out IDX_W  first set request at or after ptr+1 (circular)
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest hit overwrites
  // the others; offset N lands back on ptr itself (lowest priority).
  always_comb begin
    int cand;
    cand  = 0;
    found = 1'b0;
    idx   = ptr;
    for (int off = N; off >= 1; off--) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (req[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between N_REQ
// producers. A granted owner streams up to MAX_BURST words, one per cycle,
// honouring fifo_full; one idle arbitration cycle separates grants.
//
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   synchronous, active-low
//   bus      if   fifo_wr_arbiter_if.master (req/req_data/ack/FIFO write port)
//   owner    out  current or last granted requester (round-robin pointer)
//   busy     out  high while a grant is active
//   wr_count out  N_REQ x 16-bit write counters (only with FIFO_ARB_STATS_EN)
//
// Build option: define FIFO_ARB_STATS_EN to add the wr_count statistics.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  fifo_wr_arbiter_if.master         bus,
  output logic [clog2(N_REQ)-1:0]   owner,
  output logic                      busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0]   wr_count
`endif
);

  localparam int IDX_W   = clog2(N_REQ);
  localparam int BURST_W = clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(MAX_BURST - 1);

  arb_state_t         state, next_state;
  logic [BURST_W-1:0] burst_cnt;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_req;
  logic               wr_fire;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (owner),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_req = bus.req[owner];
  assign wr_fire   = (state == GRANT) & owner_req & ~bus.fifo_full;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // owner doubles as the round-robin pointer, so it only moves on a new grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner     <= IDX_W'(N_REQ - 1);
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_found) begin
        owner     <= pick_idx;
        burst_cnt <= '0;
      end
    end else if (wr_fire) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // A dropped request and the final burst beat may coincide; both just
  // mean "leave GRANT", so one transition covers them.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_found) next_state = GRANT;
      GRANT:   if (!owner_req || (wr_fire && burst_cnt == LAST_BEAT))
                 next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // fifo_full feeds fifo_wr_en combinationally so a full FIFO blocks the
  // write in the same cycle.
  always_comb begin
    busy             = (state == GRANT);
    bus.fifo_wr_en   = wr_fire;
    bus.fifo_wr_data = '0;
    bus.ack          = '0;
    if (state == GRANT) bus.fifo_wr_data = bus.req_data[owner*DATA_W +: DATA_W];
    if (wr_fire)        bus.ack[owner]   = 1'b1;
  end

`ifdef FIFO_ARB_STATS_EN
  // Free-running per-requester write counters; they wrap at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_count <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (bus.ack[i])
          wr_count[i*STAT_W +: STAT_W] <= wr_count[i*STAT_W +: STAT_W] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (N_REQ=4, DATA_W=8, MAX_BURST=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 3 units after the edge, well clear of both clock edges.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam logic [31:0] TBL_DATA = 32'h44332211;

  logic       clk;
  logic       reset_n;
  logic [1:0] owner;
  logic       busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*STAT_W-1:0] wr_count;
`endif

  fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus();

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk      (clk),
    .reset    (reset_n),
    .bus      (bus),
    .owner    (owner),
    .busy     (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .wr_count (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a grant is either active or not, has an owner and a
  // count of words written so far; ends after MB words or a dropped request.
  bit         m_granted;
  int         m_owner;
  int         m_writes;
  int         m_cnt [N];
  logic       cur_rst;
  logic [3:0] cur_req;
  logic [31:0] cur_data;
  logic       cur_full;
  logic       e_busy, e_wr;
  logic [1:0] e_owner;
  logic [3:0] e_ack;
  logic [7:0] e_data;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       full;
    logic       busy;
    logic [1:0] owner;
    logic       wr_en;
    logic [3:0] ack;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mkVec(input logic rn, input logic [3:0] rq, input logic fl,
                                 input logic bz, input int ow, input logic we);
    vec_t v;
    v.rst_n = rn;
    v.req   = rq;
    v.full  = fl;
    v.busy  = bz;
    v.owner = 2'(ow);
    v.wr_en = we;
    v.ack   = we ? 4'(1 << ow) : 4'h0;
    v.data  = bz ? 8'(8'h11 * (ow + 1)) : 8'h00;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelOutputs();
    e_busy  = m_granted;
    e_owner = 2'(m_owner);
    e_wr    = m_granted && cur_req[m_owner] && !cur_full;
    e_ack   = e_wr ? 4'(1 << m_owner) : 4'h0;
    e_data  = m_granted ? cur_data[m_owner*8 +: 8] : 8'h00;
  endtask

  task automatic modelUpdate();
    if (!cur_rst) begin
      m_granted = 0;
      m_owner   = N - 1;
      m_writes  = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (!m_granted) begin
      for (int off = 1; off <= N; off++) begin
        if (cur_req[(m_owner + off) % N]) begin
          m_owner   = (m_owner + off) % N;
          m_granted = 1;
          m_writes  = 0;
          break;
        end
      end
    end else begin
      if (e_wr) begin
        m_writes++;
        m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 65536;
      end
      if (!cur_req[m_owner] || m_writes == MB) m_granted = 0;
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic [3:0] rq,
                               input logic [31:0] dt, input logic fl);
    cur_rst  = rn;
    cur_req  = rq;
    cur_data = dt;
    cur_full = fl;
    reset_n       = rn;
    bus.req       = rq;
    bus.req_data  = dt;
    bus.fifo_full = fl;
    #2;
    modelOutputs();
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".busy"},  32'(busy),             32'(e_busy));
    checkValue({tag, ".owner"}, 32'(owner),            32'(e_owner));
    checkValue({tag, ".wr_en"}, 32'(bus.fifo_wr_en),   32'(e_wr));
    checkValue({tag, ".ack"},   32'(bus.ack),          32'(e_ack));
    checkValue({tag, ".data"},  32'(bus.fifo_wr_data), 32'(e_data));
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      checkValue($sformatf("%s.wr_count%0d", tag, i),
                 32'(wr_count[i*STAT_W +: STAT_W]), 32'(m_cnt[i]));
`endif
  endtask

  task automatic endCycle();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0);
    checkOutput("reset");
    endCycle();
  endtask

  initial begin
    int wr_seen;
    logic [3:0] rq;

    bus.req = '0; bus.req_data = '0; bus.fifo_full = 1'b0; reset_n = 1'b0;

    // Expected sequence with all four requesting: 0,1,2,3,0, four words
    // each, one idle cycle between grants.
    vecs[0] = mkVec(1'b0, 4'hF, 1'b0, 1'b0, 3, 1'b0);
    vecs[1] = mkVec(1'b1, 4'hF, 1'b0, 1'b0, 3, 1'b0);
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++)
        vecs[2 + g*5 + k] = mkVec(1'b1, 4'hF, 1'b0, 1'b1, g % 4, 1'b1);
      vecs[2 + g*5 + 4] = mkVec(1'b1, 4'hF, 1'b0, 1'b0, g % 4, 1'b0);
    end

    @(posedge clk);
    #1;
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0);
    endCycle();

    $display("[TB] table: round-robin over all requesters");
    for (int i = 0; i < 27; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].req, TBL_DATA, vecs[i].full);
      checkValue($sformatf("vec%0d.busy", i),  32'(busy),             32'(vecs[i].busy));
      checkValue($sformatf("vec%0d.owner", i), 32'(owner),            32'(vecs[i].owner));
      checkValue($sformatf("vec%0d.wr_en", i), 32'(bus.fifo_wr_en),   32'(vecs[i].wr_en));
      checkValue($sformatf("vec%0d.ack", i),   32'(bus.ack),          32'(vecs[i].ack));
      checkValue($sformatf("vec%0d.data", i),  32'(bus.fifo_wr_data), 32'(vecs[i].data));
      endCycle();
    end

    $display("[TB] requester 2 alone with A5");
    doReset();
    wr_seen = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 4'b0100, {4{8'hA5}}, 1'b0);
      checkOutput("solo2");
      if (bus.fifo_wr_en === 1'b1) begin
        wr_seen++;
        checkValue("solo2_owner", 32'(owner), 32'd2);
      end
      endCycle();
    end
    checkValue("solo2_writes", 32'(wr_seen), 32'd8);

    $display("[TB] fifo_full held during a grant");
    doReset();
    applyStimulus(1'b1, 4'b0100, {4{8'hA5}}, 1'b0); checkOutput("full_idle"); endCycle();
    applyStimulus(1'b1, 4'b0100, {4{8'hA5}}, 1'b0); checkOutput("full_w1");   endCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 4'b0100, {4{8'hA5}}, 1'b1);
      checkOutput("full_hold");
      checkValue("full_hold_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      checkValue("full_hold_ack",   32'(bus.ack),        32'd0);
      checkValue("full_hold_busy",  32'(busy),           32'd1);
      endCycle();
    end
    applyStimulus(1'b1, 4'b0100, {4{8'hA5}}, 1'b0);
    checkOutput("full_resume");
    checkValue("full_resume_wr_en", 32'(bus.fifo_wr_en), 32'd1);
    endCycle();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 4'b0100, {4{8'hA5}}, 1'b0); checkOutput("full_tail"); endCycle();
    end
    applyStimulus(1'b1, 4'b0100, {4{8'hA5}}, 1'b0);
    checkValue("full_burst_end_busy", 32'(busy), 32'd0);
    endCycle();

    $display("[TB] owner drops request after two writes");
    doReset();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 4'b0011, TBL_DATA, 1'b0); checkOutput("drop_pre"); endCycle();
    end
    applyStimulus(1'b1, 4'b0010, TBL_DATA, 1'b0);
    checkOutput("drop_cycle");
    checkValue("drop_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    endCycle();
    applyStimulus(1'b1, 4'b0010, TBL_DATA, 1'b0);
    checkValue("drop_idle_busy", 32'(busy), 32'd0);
    endCycle();
    applyStimulus(1'b1, 4'b0010, TBL_DATA, 1'b0);
    checkOutput("drop_next");
    checkValue("drop_next_owner", 32'(owner), 32'd1);
    checkValue("drop_next_wr_en", 32'(bus.fifo_wr_en), 32'd1);
    endCycle();

    $display("[TB] reset mid-burst");
    doReset();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 4'hF, TBL_DATA, 1'b0); checkOutput("mid_pre"); endCycle();
    end
    applyStimulus(1'b0, 4'hF, TBL_DATA, 1'b0); checkOutput("mid_assert"); endCycle();
    applyStimulus(1'b1, 4'h0, TBL_DATA, 1'b0);
    checkValue("mid_busy",  32'(busy),           32'd0);
    checkValue("mid_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    checkValue("mid_owner", 32'(owner),          32'd3);
    endCycle();

`ifdef FIFO_ARB_STATS_EN
    $display("[TB] write counters");
    doReset();
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b1, 4'b0010, TBL_DATA, 1'b0); checkOutput("stats"); endCycle();
    end
    applyStimulus(1'b1, 4'b0000, TBL_DATA, 1'b0); checkOutput("stats_end"); endCycle();
    for (int i = 0; i < N; i++)
      checkValue($sformatf("stats_count%0d", i), 32'(wr_count[i*STAT_W +: STAT_W]),
                 (i == 1) ? 32'd5 : 32'd0);
`endif

    $display("[TB] randomized traffic against model");
    doReset();
    rq = 4'h0;
    for (int c = 0; c < 400; c++) begin
      rq = rq ^ (4'($urandom) & 4'($urandom));
      applyStimulus(($urandom_range(0, 63) != 0), rq, $urandom, ($urandom_range(0, 3) == 0));
      checkOutput($sformatf("rand%0d", c));
      endCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the 8-bit synchronous FIFO between several producers. Each producer presents a request and a data word; the arbiter grants one owner at a time and lets it write up to a bounded burst. It drives the FIFO's `wr_en`/`wr_data` directly and honours `full`, so no producer ever writes into a full FIFO. It sits between the producer blocks and the FIFO write port.

## Interface
- `N_REQ`, default 4: number of requesters, from 2 to 8.
- `DATA_W`, default 8: word width, matching the FIFO width.
- `MAX_BURST`, default 4: maximum writes per grant before forced rotation, 1 or more.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req`  in  N_REQ  per-requester request, level; held until the word is acked.
- `req_data`  in  N_REQ*DATA_W  packed data, requester i in bits [i*DATA_W +: DATA_W].
- `ack`  out  N_REQ  one-hot, one-cycle pulse when requester i's word is written this cycle.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_wr_data`  out  DATA_W  to FIFO `wr_data`.
- `fifo_full`  in  1  from FIFO `full`.
- `owner`  out  clog2(N_REQ)  current/last granted requester index.
- `busy`  out  1  high while in GRANT.
- `wr_count`  out  N_REQ*16  per-requester write counters; present only with FIFO_ARB_STATS_EN.

## Operation
- FSM has two states.
  - IDLE: arbitrate.
  - GRANT: stream writes from `owner`.
- In IDLE, if any `req` is high, pick the first set request searching circularly from `owner+1`. Register that index into `owner`, clear the burst counter, and go to GRANT. No write occurs in the IDLE cycle.
- In GRANT:
  - `fifo_wr_en = req[owner] & ~fifo_full`.
  - `fifo_wr_data = req_data[owner]`.
  - `ack[owner] = fifo_wr_en`.
  - These outputs are combinational from registered state.
- Each write increments the burst counter (width clog2(MAX_BURST+1)).
- GRANT goes to IDLE at the edge where either:
  - `req[owner]` is low, or
  - a write occurs with burst count equal to MAX_BURST-1.
- When `fifo_full` is high in GRANT: no write, no ack, counter holds, grant is held. There is no timeout.
- A requester deasserting `req` without an ack is legal. Its word is dropped by the requester, not by this block.
- `owner` persists in IDLE as the round-robin pointer.
- Reset values:
  - state IDLE, `owner` = N_REQ-1 so requester 0 wins first, burst counter 0.
  - `busy` 0, `ack` 0, `fifo_wr_en` 0, `fifo_wr_data` 0.
  - `wr_count` all 0.
- Reset asserted mid-burst: at the next edge return to IDLE with all reset values. Outputs go low in the same cycle the FSM leaves GRANT. Any partial burst is abandoned.

## Timing
- Grant latency: a request seen in IDLE at edge k gives GRANT from edge k+1. The first write can occur in cycle k+1.
- Throughput: one word per cycle inside a burst. There is one idle arbitration cycle between grants.
- `fifo_full` has a zero-cycle effect on `fifo_wr_en` (combinational path, no register).
- The FIFO's `full` rises after its last free slot is written, so the write that fills it is legal and the next write is suppressed.
- Simultaneous last write (count MAX_BURST-1) and `req` drop: single transition to IDLE.
- When the pointer is at N_REQ-1, the next search starts at 0 (wrap-around).

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds N_REQ 16-bit counters on `wr_count`, each incremented on its `ack`.
  - Counters wrap from 0xFFFF to 0 and are cleared by `reset`.
- Not defined: the `wr_count` port and the counters are absent, with no other behavioural change.

## Structure
- Package `fifo_arb_pkg` holds:
  - the FSM state encoding (IDLE = 1'b0, GRANT = 1'b1);
  - the counter width constant (16);
  - the clog2 helper.
- Sub-module `rr_pick`: combinational circular priority search, with inputs `req` and `ptr` and outputs `found` and `idx`.
- The top level contains the FSM, burst counter, output muxing and the optional stats counters.

## Test plan
- Reset with `req`=4'b1111 held, then release. Required: first grant to 0, then 1, 2, 3, 0; each grant writes 4 words (MAX_BURST=4) with a 1-cycle gap between grants.
- Only requester 2 requests, with data 8'hA5, for 10 cycles. Required: writes of A5 in bursts of 4, with an IDLE cycle between bursts, and requester 2 regranted each time.
- Hold `fifo_full`=1 during a grant for 3 cycles. Required: no `fifo_wr_en` and no `ack`, the burst count holds, and writes resume the cycle full drops.
- Owner drops `req` after 2 writes. Required: return to IDLE and the next requester is granted.
- Assert `reset`=0 mid-burst. Required: next cycle `busy`=0, `fifo_wr_en`=0, `owner`=N_REQ-1.
- With FIFO_ARB_STATS_EN, write 5 words from requester 1. Required: `wr_count[1]`=5 and all others 0.
